ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/k_and_s_pkg.sv | 20 ++
 rtl/arb_pick.sv | 33 +++
 rtl/ram_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared widths, burst limit and enumerations for the CPU/DMA RAM arbiter.
package k_and_s_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int BURST_MAX = 8;
    localparam int BEAT_W    = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: round-robin between CPU and DMA with a
// bounded DMA burst-lock override.
module arb_pick
    import k_and_s_pkg::*;
(
    input  logic              cpu_req,
    input  logic              dma_req,
    input  arb_owner_t        last_grant,
    input  logic              dma_lock,
    input  logic [BEAT_W-1:0] beat_cnt,
    output logic              grant_valid,
    output arb_owner_t        winner
);

    logic burst_hold;

    always_comb begin
        grant_valid = cpu_req | dma_req;
        winner      = OWN_CPU;
        // The locked DMA keeps ownership only until it has used up its burst allowance.
        burst_hold  = (last_grant == OWN_DMA) && dma_lock && (beat_cnt < BEAT_W'(BURST_MAX));
        if (dma_req && !cpu_req) begin
            winner = OWN_DMA;
        end else if (dma_req && cpu_req) begin
            if (burst_hold || last_grant == OWN_CPU) begin
                winner = OWN_DMA;
            end else begin
                winner = OWN_CPU;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single-port RAM with one-cycle read
// latency; each grant runs IDLE -> ACCESS -> RESP.
module ram_arbiter
    import k_and_s_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

    arb_state_t        state_reg, state_next;
    arb_owner_t        last_reg;
    arb_owner_t        owner_reg;
    logic [BEAT_W-1:0] beat_cnt_reg;
    logic              cap_we_reg;
    logic [ADDR_W-1:0] cap_addr_reg;
    logic [DATA_W-1:0] cap_wdata_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] dma_rdata_reg;

    logic              grant_valid;
    arb_owner_t        winner;
    logic              grant;
    logic              in_access;
    logic              in_resp;

    arb_pick u_pick (
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .last_grant  (last_reg),
        .dma_lock    (dma_lock),
        .beat_cnt    (beat_cnt_reg),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACCESS;
                    grant      = 1'b1;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            last_reg      <= OWN_DMA;
            owner_reg     <= OWN_CPU;
            beat_cnt_reg  <= '0;
            cap_we_reg    <= 1'b0;
            cap_addr_reg  <= '0;
            cap_wdata_reg <= '0;
            cpu_rdata_reg <= '0;
            dma_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                last_reg  <= winner;
                owner_reg <= winner;
                if (winner == OWN_DMA) begin
                    cap_we_reg    <= dma_we;
                    cap_addr_reg  <= dma_addr;
                    cap_wdata_reg <= dma_wdata;
                end else begin
                    cap_we_reg    <= cpu_we;
                    cap_addr_reg  <= cpu_addr;
                    cap_wdata_reg <= cpu_wdata;
                end
            end
            if (state_reg == IDLE) begin
                if (grant && winner == OWN_CPU) begin
                    beat_cnt_reg <= '0;
                end else if (grant && dma_lock) begin
                    if (beat_cnt_reg < BEAT_W'(BURST_MAX)) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                end else if (!dma_lock) begin
                    beat_cnt_reg <= '0;
                end
            end
            // Keep the last returned word so rdata stays stable between acks.
            if (state_reg == RESP) begin
                if (owner_reg == OWN_CPU) begin
                    cpu_rdata_reg <= ram_rdata;
                end else begin
                    dma_rdata_reg <= ram_rdata;
                end
            end
        end
    end

    // Reset gates the RAM strobes immediately so an in-flight write is dropped.
    always_comb begin
        in_access = (state_reg == ACCESS) && !rst;
        in_resp   = (state_reg == RESP) && !rst;
        ram_en    = in_access;
        ram_we    = in_access && cap_we_reg;
        ram_addr  = in_access ? cap_addr_reg : '0;
        ram_wdata = in_access ? cap_wdata_reg : '0;
        cpu_ack   = in_resp && (owner_reg == OWN_CPU);
        dma_ack   = in_resp && (owner_reg == OWN_DMA);
        cpu_rdata = cpu_ack ? ram_rdata : cpu_rdata_reg;
        dma_rdata = dma_ack ? ram_rdata : dma_rdata_reg;
        busy      = (state_reg != IDLE);
        owner     = owner_reg;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioral one-cycle-latency RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [7:0]  cpu_addr, dma_addr;
    logic [15:0] cpu_wdata, dma_wdata;
    logic        cpu_ack, dma_ack;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0;
    logic        busy, owner;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [256];
    bit          written [256];

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_lock  (dma_lock),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    function automatic logic [15:0] preset(input logic [7:0] a);
        case (a)
            8'h10:   preset = 16'h1234;
            8'h11:   preset = 16'h5678;
            8'h20:   preset = 16'h1111;
            default: preset = 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] peek(input logic [7:0] a);
        peek = written[a] ? mem[a] : preset(a);
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= peek(ram_addr);
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    bit          ok;
    int          gap;
    int          beat;
    logic        exp_own;

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_lock = 0;
        step;
        step;
        chk("reset_busy", busy, 0);
        chk("reset_owner", owner, 0);
        chk("reset_acks", {cpu_ack, dma_ack}, 0);
        chk("reset_ram_en", ram_en, 0);
        chk("reset_rdata", {cpu_rdata, dma_rdata}, 0);
        rst = 1'b0;

        // CPU read of 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        step;
        chk("rd_access_en", {ram_en, ram_we}, 2'b10);
        chk("rd_access_addr", ram_addr, 8'h10);
        chk("rd_access_busy", busy, 1);
        chk("rd_access_noack", {cpu_ack, dma_ack}, 0);
        step;
        chk("rd_resp_ack", {cpu_ack, dma_ack}, 2'b10);
        chk("rd_resp_data", cpu_rdata, 16'h1234);
        chk("rd_resp_en", ram_en, 0);
        cpu_req = 0;
        step;
        chk("rd_idle_ack", {cpu_ack, dma_ack}, 0);
        chk("rd_idle_hold", cpu_rdata, 16'h1234);
        chk("rd_idle_busy", busy, 0);

        // Simultaneous requests after reset: CPU first, then DMA
        rst = 1'b1;
        step;
        rst = 1'b0;
        cpu_req = 1; cpu_addr = 8'h10;
        dma_req = 1; dma_we = 0; dma_addr = 8'h11;
        step;
        chk("tie_first_owner", owner, 0);
        chk("tie_first_addr", ram_addr, 8'h10);
        step;
        chk("tie_first_ack", {cpu_ack, dma_ack}, 2'b10);
        cpu_req = 0;
        step;
        chk("tie_gap_idle", {busy, ram_en}, 0);
        step;
        chk("tie_second_owner", owner, 1);
        chk("tie_second_addr", ram_addr, 8'h11);
        step;
        chk("tie_second_ack", {cpu_ack, dma_ack}, 2'b01);
        chk("tie_second_data", dma_rdata, 16'h5678);
        dma_req = 0;
        step;
        chk("tie_done_ack", {cpu_ack, dma_ack}, 0);

        // Locked DMA burst of 12 writes with CPU contending
        beat = 0;
        dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 8'h40; dma_wdata = 16'hA000;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        for (int g = 0; g < 13; g++) begin
            ok = 0;
            gap = 0;
            for (int k = 0; k < 6; k++) begin
                step;
                if (ram_en === 1'b1) begin
                    ok = 1;
                    break;
                end
                gap++;
            end
            chk($sformatf("burst_grant_seen_%0d", g), ok, 1);
            chk($sformatf("burst_spacing_%0d", g), gap, (g == 0) ? 0 : 1);
            exp_own = (g == 8) ? 1'b0 : 1'b1;
            chk($sformatf("burst_owner_%0d", g), owner, exp_own);
            if (exp_own) begin
                chk($sformatf("burst_wdata_%0d", g), ram_wdata, 16'hA000 + beat);
            end
            step;
            if (exp_own) begin
                chk($sformatf("burst_dma_ack_%0d", g), {cpu_ack, dma_ack}, 2'b01);
                beat++;
                if (beat == 12) begin
                    dma_req = 0;
                end else begin
                    dma_addr  = 8'h40 + 8'(beat);
                    dma_wdata = 16'hA000 + 16'(beat);
                end
            end else begin
                chk($sformatf("burst_cpu_ack_%0d", g), {cpu_ack, dma_ack}, 2'b10);
                cpu_req = 0;
            end
        end
        step;
        chk("burst_mem_first", peek(8'h40), 16'hA000);
        chk("burst_mem_last", peek(8'h4B), 16'hA00B);
        chk("burst_idle", busy, 0);

        // DMA write aborted by reset during ACCESS
        dma_lock = 0; dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 16'hBEEF;
        step;
        chk("abort_pre_we", {ram_en, ram_we}, 2'b11);
        rst = 1'b1;
        #1;
        chk("abort_rst_we", {ram_en, ram_we}, 2'b00);
        step;
        chk("abort_no_ack", {cpu_ack, dma_ack}, 0);
        chk("abort_idle", busy, 0);
        rst = 1'b0;
        dma_req = 0;
        step;
        chk("abort_no_ack_later", dma_ack, 0);
        chk("abort_mem", peek(8'h20), 16'h1111);

        // CPU write then DMA read back
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 16'h00FF;
        step;
        chk("wr_access", {ram_en, ram_we, owner}, 3'b110);
        chk("wr_wdata", ram_wdata, 16'h00FF);
        step;
        chk("wr_ack", {cpu_ack, dma_ack}, 2'b10);
        cpu_req = 0;
        step;
        dma_req = 1; dma_we = 0; dma_addr = 8'h05;
        step;
        chk("rb_access", {ram_en, ram_we, owner}, 3'b101);
        step;
        chk("rb_ack", {cpu_ack, dma_ack}, 2'b01);
        chk("rb_data", dma_rdata, 16'h00FF);
        dma_req = 0;
        step;
        chk("rb_hold", dma_rdata, 16'h00FF);
        chk("rb_ack_gone", dma_ack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
